// File: rtl/csr_bus_arbiter.sv
// Two-master round-robin arbiter in front of the single cdbus CSR port.
// Serialises one access at a time; read data returns with a per-master valid pulse.
module csr_bus_arbiter #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_waitrequest,
  output logic              s_chip_select,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata
);

  localparam int unsigned LAT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RDDONE} state_t;

  state_t             state;
  logic               grant;
  logic               last_grant;
  logic               op_write;
  logic [LAT_W-1:0]   lat_cnt;

  logic req0, req1, sel, done, req_g;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  // On conflict the port that did not win last time gets the bus.
  assign sel   = (req0 & req1) ? ~last_grant : req1;
  assign done  = ((state == ISSUE) & op_write) | (state == RDDONE);
  assign req_g = grant ? req1 : req0;

  assign m0_waitrequest = ~reset & req0 & ~(done & ~grant);
  assign m1_waitrequest = ~reset & req1 & ~(done & grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      grant            <= 1'b0;
      last_grant       <= 1'b1;
      op_write         <= 1'b0;
      lat_cnt          <= '0;
      s_chip_select    <= 1'b0;
      s_read           <= 1'b0;
      s_write          <= 1'b0;
      s_address        <= '0;
      s_writedata      <= '0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
    end else begin
      s_chip_select    <= 1'b0;
      s_read           <= 1'b0;
      s_write          <= 1'b0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant <= sel;
            if (req0 & req1) last_grant <= sel;
            op_write      <= sel ? m1_write : m0_write;
            s_address     <= sel ? m1_address : m0_address;
            s_writedata   <= sel ? m1_writedata : m0_writedata;
            s_chip_select <= 1'b1;
            s_write       <= sel ? m1_write : m0_write;
            s_read        <= sel ? ~m1_write : ~m0_write;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_write) begin
            state <= IDLE;
          end else begin
            lat_cnt <= LAT_W'(READ_LAT - 1);
            state   <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (lat_cnt == '0) begin
            // A requester that dropped mid-read gets nothing back.
            if (req_g) begin
              if (grant) begin
                m1_readdata      <= s_readdata;
                m1_readdatavalid <= 1'b1;
              end else begin
                m0_readdata      <= s_readdata;
                m0_readdatavalid <= 1'b1;
              end
            end
            state <= RDDONE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RDDONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
